// File: rtl/move_pulse_generator_if.sv
// rtl/move_pulse_generator_if.sv - switch levels in, movement/start strobes out
interface move_pulse_generator_if;
    logic [3:0] i_Buttons;
    logic       o_Up_Pulse;
    logic       o_Down_Pulse;
    logic       o_Left_Pulse;
    logic       o_Right_Pulse;
    logic       o_Start_Pulse;
    logic       o_Chord_Active;

    modport master (
        output i_Buttons,
        input  o_Up_Pulse, o_Down_Pulse, o_Left_Pulse, o_Right_Pulse,
        input  o_Start_Pulse, o_Chord_Active
    );

    modport slave (
        input  i_Buttons,
        output o_Up_Pulse, o_Down_Pulse, o_Left_Pulse, o_Right_Pulse,
        output o_Start_Pulse, o_Chord_Active
    );
endinterface

// File: rtl/move_pulse_generator.sv
// rtl/move_pulse_generator.sv - switch levels to move strobes with hold-repeat and start chord
// Optional auto-repeat enabled by defining MOVE_AUTO_REPEAT_EN.
module move_pulse_generator #(
    parameter int HOLD_DELAY    = 12_500_000,
    parameter int REPEAT_PERIOD = 5_000_000,
    parameter int START_HOLD    = 25_000_000
) (
    input  logic                   i_Clk,
    input  logic                   i_Reset,
    move_pulse_generator_if.slave  bus
);
    localparam int MAX_HR = (HOLD_DELAY > REPEAT_PERIOD) ? HOLD_DELAY : REPEAT_PERIOD;
    localparam int MAX_P  = (MAX_HR > START_HOLD) ? MAX_HR : START_HOLD;
    localparam int CW     = $clog2(MAX_P) + 1;

    localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_DELAY - 1);
    localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_PERIOD - 1);
    localparam logic [CW-1:0] START_LAST  = CW'(START_HOLD - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_HELD   = 3'd1;
    localparam logic [2:0] S_REPEAT = 3'd2;
    localparam logic [2:0] S_CHORD  = 3'd3;
    localparam logic [2:0] S_WAIT   = 3'd4;

    logic [2:0]    state, state_nx;
    logic [CW-1:0] count, count_nx;
    logic [3:0]    latched, latched_nx;
    logic [3:0]    move_nx, move_q;
    logic          start_nx, start_q, chord_q;

    logic [3:0] btn;
    logic       single;
    logic       others;
    logic       all_four;
    logic [CW-1:0] chord_entry_count;

    assign btn      = bus.i_Buttons;
    assign single   = (btn != 4'd0) && ((btn & (btn - 4'd1)) == 4'd0);
    assign others   = (btn & ~latched) != 4'd0;
    assign all_four = (btn == 4'hF);
    // The sample that enters the chord already counts toward the start hold.
    assign chord_entry_count = all_four ? CW'(1) : '0;

    always_comb begin
        state_nx   = state;
        count_nx   = count;
        latched_nx = latched;
        move_nx    = 4'd0;
        start_nx   = 1'b0;
        case (state)
            S_IDLE: begin
                if (single) begin
                    move_nx    = btn;
                    latched_nx = btn;
                    state_nx   = S_HELD;
                    count_nx   = '0;
                end else if (btn != 4'd0) begin
                    state_nx = S_CHORD;
                    count_nx = chord_entry_count;
                end
            end
            S_HELD: begin
                if (others) begin
                    state_nx = S_CHORD;
                    count_nx = chord_entry_count;
                end else if (btn == 4'd0) begin
                    state_nx = S_IDLE;
                    count_nx = '0;
                end else begin
`ifdef MOVE_AUTO_REPEAT_EN
                    if (count == HOLD_LAST) begin
                        move_nx  = latched;
                        state_nx = S_REPEAT;
                        count_nx = '0;
                    end else begin
                        count_nx = count + CW'(1);
                    end
`else
                    count_nx = '0;
`endif
                end
            end
`ifdef MOVE_AUTO_REPEAT_EN
            S_REPEAT: begin
                if (others) begin
                    state_nx = S_CHORD;
                    count_nx = chord_entry_count;
                end else if (btn == 4'd0) begin
                    state_nx = S_IDLE;
                    count_nx = '0;
                end else if (count == REPEAT_LAST) begin
                    move_nx  = latched;
                    count_nx = '0;
                end else begin
                    count_nx = count + CW'(1);
                end
            end
`endif
            S_CHORD: begin
                if (btn == 4'd0) begin
                    state_nx = S_IDLE;
                    count_nx = '0;
                end else if (all_four) begin
                    if (count == START_LAST) begin
                        start_nx = 1'b1;
                        state_nx = S_WAIT;
                        count_nx = '0;
                    end else begin
                        count_nx = count + CW'(1);
                    end
                end else begin
                    count_nx = '0;
                end
            end
            S_WAIT: begin
                if (btn == 4'd0) begin
                    state_nx = S_IDLE;
                    count_nx = '0;
                end
            end
            default: begin
                state_nx = S_WAIT;
                count_nx = '0;
            end
        endcase
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state   <= S_WAIT;
            count   <= '0;
            latched <= 4'd0;
            move_q  <= 4'd0;
            start_q <= 1'b0;
            chord_q <= 1'b0;
        end else begin
            state   <= state_nx;
            count   <= count_nx;
            latched <= latched_nx;
            move_q  <= move_nx;
            start_q <= start_nx;
            // Chord indication stays up through the start strobe cycle.
            chord_q <= (state_nx == S_CHORD) || start_nx;
        end
    end

    assign bus.o_Up_Pulse     = move_q[0];
    assign bus.o_Down_Pulse   = move_q[1];
    assign bus.o_Left_Pulse   = move_q[2];
    assign bus.o_Right_Pulse  = move_q[3];
    assign bus.o_Start_Pulse  = start_q;
    assign bus.o_Chord_Active = chord_q;
endmodule

// File: doc/move_pulse_generator.md
# move_pulse_generator

Converts the four debounced switch levels into single-cycle movement strobes for the game core, with hold-to-repeat and a four-switch "start" chord. Sits between `multi_button_debouncer` and `frogger_game`. It replaces the raw level wiring of switches to the up/down/left/right and game-start inputs. Every output is registered in the `i_Clk` domain.

## Interface
Parameters:
- `HOLD_DELAY`, 12_500_000: cycles between the first strobe and the first auto-repeat strobe (0.5 s at 25 MHz).
- `REPEAT_PERIOD`, 5_000_000: cycles between subsequent auto-repeat strobes.
- `START_HOLD`, 25_000_000: cycles that all four switches must be held together to issue start.

Ports:
- `i_Clk`  in  1  system clock (pixel clock domain).
- `i_Reset`  in  1  asynchronous, active-high reset.
- `i_Buttons`  in  4  debounced levels; bit0 up, bit1 down, bit2 left, bit3 right.
- `o_Up_Pulse`, `o_Down_Pulse`, `o_Left_Pulse`, `o_Right_Pulse`  out  1 each  single-cycle move strobes.
- `o_Start_Pulse`  out  1  single-cycle game-start strobe.
- `o_Chord_Active`  out  1  high while in CHORD.

## Operation
- Reset: all outputs 0, counter 0, state WAIT_RELEASE. A switch held through reset never produces a strobe.
- Counter width: `$clog2` of the largest of the three parameters, plus 1. The counter clears on every state entry.
- States and transitions:
  - **IDLE**
    - Exactly one bit set: strobe that direction and go to HELD, latching the bit.
    - Two or more bits set: go to CHORD with no strobe.
  - **HELD**
    - Counter increments each cycle.
    - Latched bit drops and no bits set: go to IDLE.
    - Any other bit set: go to CHORD with no strobe. This check takes priority over the counter expiring in the same cycle.
    - Counter reaches `HOLD_DELAY-1`: strobe and go to REPEAT.
  - **REPEAT**
    - Same release and chord rules as HELD.
    - Counter wraps at `REPEAT_PERIOD-1`, issuing a strobe at each wrap.
  - **CHORD**
    - All four set: counter increments. At `START_HOLD-1`, pulse `o_Start_Pulse` and go to WAIT_RELEASE.
    - Fewer than four set: counter held at 0.
    - Zero set: go to IDLE.
    - No move strobes are issued in CHORD.
  - **WAIT_RELEASE**
    - No strobes.
    - Go to IDLE when `i_Buttons == 0`.
- At most one output strobe is high in any cycle.

## Timing
- Offsets are counted from cycle 0, the first rising edge that samples the new `i_Buttons` value.
- First move strobe: high during cycle 1, for exactly one cycle.
- Auto-repeat strobes: at offsets `1+HOLD_DELAY`, then every `REPEAT_PERIOD` cycles.
- Start strobe: at offset `START_HOLD` after all four are first sampled high together.
- A release (or added bit) sampled at cycle n cancels any strobe that would otherwise have fired at n+1.
- `i_Reset` assertion clears all outputs asynchronously, mid-strobe included. State leaves WAIT_RELEASE only after release is sampled on clock edges following reset deassertion.

## Configuration
- `MOVE_AUTO_REPEAT_EN` defined:
  - HELD transitions to REPEAT and strobes as described above.
- `MOVE_AUTO_REPEAT_EN` undefined:
  - HELD never expires; one strobe per press.
  - The REPEAT state and repeat counter logic are not synthesized.
  - `REPEAT_PERIOD` is unused.

## Test plan
Bench parameters: `HOLD_DELAY=8`, `REPEAT_PERIOD=4`, `START_HOLD=16`; macro defined unless noted.

- **Reset with switch held:** hold `i_Buttons=4'b0001` through reset, then release, then press again for 1 cycle -> no strobe before the release; one `o_Up_Pulse` at offset 1 of the new press.
- **Auto-repeat:** hold up for 20 cycles -> `o_Up_Pulse` at offsets 1, 9, 13, 17 only; no other output toggles.
- **Chord entry:** go from `4'b0000` straight to `4'b0110` for 30 cycles -> no move strobes, `o_Chord_Active=1` from offset 1, no start; release -> IDLE.
- **Start chord:** hold `4'b1111` for 40 cycles -> exactly one `o_Start_Pulse` at offset 16, `o_Chord_Active` falls at 17; no further strobes until all released and a new press.
- **Macro undefined:** hold left for 50 cycles -> exactly one `o_Left_Pulse` at offset 1.
- **Reset mid-repeat:** assert `i_Reset` asynchronously during the offset-13 strobe -> `o_Up_Pulse` drops without waiting for a clock edge; no strobe while up remains held after deassertion.
